mux_nx1_seq: RTL



---
 rtl/mux_pkg.sv | 9 +
 rtl/mux_nx1_seq_if.sv | 29 ++
 rtl/mux_scan_ctrl.sv | 57 +++++
 rtl/mux_nx1_seq.sv | 87 ++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 sequential multiplexer slice.
package mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

endpackage

// File: rtl/mux_nx1_seq_if.sv
// Channel-side and downstream-side signals of mux_nx1_seq.
// The slave modport is the mux; the master modport is whoever drives it.
interface mux_nx1_seq_if #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4
);
  localparam int SEL_W = $clog2(N_CH);

  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic                  mode;
  logic [SEL_W-1:0]      select;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, mode, select, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  in_data, in_valid, mode, select, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );

endinterface

// File: rtl/mux_scan_ctrl.sv
// Round-robin scan sequencer: fixed TDM slots of DWELL cycles per channel,
// frozen while the output stalls and restarted at channel 0 on entry to scan.
module mux_scan_ctrl
  import mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int DWELL = 4,
  localparam int SEL_W = $clog2(N_CH),
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             stall,
  output logic [SEL_W-1:0] cur_ch
);

  localparam logic [DW_W-1:0]  LAST_SLOT = DW_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(N_CH - 1);

  mode_e            mode_q;
  logic [SEL_W-1:0] ch_q;
  logic [DW_W-1:0]  dwell_q;
  logic             restart;
  logic [SEL_W-1:0] ch_eff;
  logic [DW_W-1:0]  dwell_eff;

  // The first scan cycle after manual mode already counts as slot 0 of channel 0,
  // so the restarted values are used combinationally in that same cycle.
  assign restart   = (mode == MODE_SCAN) && (mode_q == MODE_MANUAL);
  assign ch_eff    = restart ? '0 : ch_q;
  assign dwell_eff = restart ? '0 : dwell_q;
  assign cur_ch    = ch_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_MANUAL;
      ch_q    <= '0;
      dwell_q <= '0;
    end else begin
      mode_q <= mode_e'(mode);
      if (mode == MODE_SCAN) begin
        if (stall) begin
          ch_q    <= ch_eff;
          dwell_q <= dwell_eff;
        end else if (dwell_eff == LAST_SLOT) begin
          ch_q    <= (ch_eff == LAST_CH) ? '0 : ch_eff + SEL_W'(1);
          dwell_q <= '0;
        end else begin
          ch_q    <= ch_eff;
          dwell_q <= dwell_eff + DW_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mux_nx1_seq.sv
// N-channel WIDTH-bit multiplexer with a registered valid/ready output stage,
// selecting either an external channel index or a round-robin scan schedule.
module mux_nx1_seq
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int DWELL = 4
) (
  input logic          clk,
  input logic          rst_n,
  mux_nx1_seq_if.slave bus
);

  localparam int SEL_W = $clog2(N_CH);

  logic [SEL_W-1:0] cur_ch;
  logic [SEL_W-1:0] act;
  logic             act_legal;
  logic             can_load;
  logic             stall;
  logic             xfer;
  logic [N_CH-1:0]  ready_vec;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] ch_q;
  logic             valid_q;

  mux_scan_ctrl #(
    .N_CH  (N_CH),
    .DWELL (DWELL)
  ) u_scan_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .mode   (bus.mode),
    .stall  (stall),
    .cur_ch (cur_ch)
  );

  assign act = (bus.mode == MODE_SCAN) ? cur_ch : bus.select;

  // Only a non-power-of-two channel count leaves select codes with no channel behind them.
  generate
    if (N_CH == (1 << SEL_W)) begin : g_full_range
      assign act_legal = 1'b1;
    end else begin : g_part_range
      assign act_legal = (act < SEL_W'(N_CH));
    end
  endgenerate

  assign can_load = !valid_q || bus.out_ready;
  assign stall    = valid_q && !bus.out_ready;

  always_comb begin
    ready_vec = '0;
    sel_data  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (SEL_W'(k) == act) begin
        ready_vec[k] = can_load && act_legal;
        sel_data     = bus.in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = |(ready_vec & bus.in_valid);

  // Output stage: load on transfer, drop valid once consumed, otherwise hold the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else if (xfer) begin
      data_q  <= sel_data;
      ch_q    <= act;
      valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready_vec;
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;

endmodule
